serial_greater_than: RTL and testbench

- Upstream sequencer for the 2-bit greater-than stage; compares two W-bit unsigned operands by feeding that stage one 2-bit slice pair per cycle, MSB slice first.
- Consumes the stage's single-bit result and evaluates slice equality locally.
- Exits early on the first unequal slice.
- Produces registered gt/eq/lt flags with a start/done handshake.

---
 rtl/serial_greater_than.sv | 145 ++++++++++++++
 tb/tb_serial_greater_than.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_greater_than.sv
// serial_greater_than: compares two W-bit unsigned operands two bits at a
// time, MSB slice first, by driving an external 2-bit greater-than stage and
// reading back its combinational slc_gt. Slice equality is evaluated here.
// Default build exits on the first unequal slice. Defining
// SERIAL_CMP_FULLSCAN_EN always scans all N slices for constant latency and
// keeps the verdict of the most significant unequal slice.
module serial_greater_than #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [1:0]   a_slc,
  output logic [1:0]   b_slc,
  input  logic         slc_gt,
  output logic         busy,
  output logic         done,
  output logic         gt,
  output logic         eq,
  output logic         lt
);

  localparam int N  = W / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [IW-1:0]  idx;
  logic           slc_eq;
  logic           last_slc;
  logic           res_gt;
  logic           res_eq;

`ifdef SERIAL_CMP_FULLSCAN_EN
  logic           decided;
  logic           dec_gt;
`endif

  // Slice mux: registered operands feed the 2-bit stage; idle drives zeros,
  // DONE keeps showing the last compared slice because idx is not advanced
  // on the exit cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    a_slc = 2'b00;
    b_slc = 2'b00;
    if (state != IDLE) begin
      a_slc = a_r[{idx, 1'b0} +: 2];
      b_slc = b_r[{idx, 1'b0} +: 2];
    end
  end

  assign slc_eq   = (a_slc == b_slc);
  assign last_slc = (idx == '0);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Verdict that would be registered if CMP finished this cycle.
  always_comb begin
    res_eq = slc_eq;
    res_gt = !slc_eq && slc_gt;
`ifdef SERIAL_CMP_FULLSCAN_EN
    if (decided) begin
      res_eq = 1'b0;
      res_gt = dec_gt;
    end
`endif
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = CMP;
`ifdef SERIAL_CMP_FULLSCAN_EN
      CMP:  if (last_slc) state_nx = DONE;
`else
      CMP:  if (!slc_eq || last_slc) state_nx = DONE;
`endif
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, operand, index and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      idx   <= '0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
`ifdef SERIAL_CMP_FULLSCAN_EN
      decided <= 1'b0;
      dec_gt  <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            a_r <= a;
            b_r <= b;
            idx <= IW'(N - 1);
`ifdef SERIAL_CMP_FULLSCAN_EN
            decided <= 1'b0;
            dec_gt  <= 1'b0;
`endif
          end
        end
        CMP: begin
          if (state_nx == DONE) begin
            gt <= res_gt;
            eq <= res_eq;
            lt <= !res_eq && !res_gt;
          end else begin
            idx <= idx - 1'b1;
          end
`ifdef SERIAL_CMP_FULLSCAN_EN
          if (!decided && !slc_eq) begin
            decided <= 1'b1;
            dec_gt  <= slc_gt;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_greater_than.sv
// tb_serial_greater_than: directed and randomized compares against an
// arithmetic reference (a > b, a == b, a < b, slice count from the MSB).
module tb_serial_greater_than;

  localparam int W = 8;
  localparam int N = W / 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   a_slc;
  logic [1:0]   b_slc;
  logic         slc_gt;
  logic         busy;
  logic         done;
  logic         gt;
  logic         eq;
  logic         lt;

  int tests = 0;
  int fails = 0;

  // Behavioural 2-bit greater-than stage.
  assign slc_gt = (a_slc > b_slc);

  always #5 clk = ~clk;

  serial_greater_than #(.W(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .a_slc  (a_slc),
    .b_slc  (b_slc),
    .slc_gt (slc_gt),
    .busy   (busy),
    .done   (done),
    .gt     (gt),
    .eq     (eq),
    .lt     (lt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] slice_of(input logic [W-1:0] v, input int i);
    return 2'((v >> (2 * i)) & 3);
  endfunction

  // Slices examined: up to and including the first unequal one from the MSB.
  function automatic int slices_needed(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_CMP_FULLSCAN_EN
    return N;
`else
    for (int i = N - 1; i >= 0; i--)
      if (slice_of(x, i) != slice_of(y, i)) return N - i;
    return N;
`endif
  endfunction

  // Run one compare starting in an IDLE cycle. If poke is set, start is
  // re-asserted with different operands in cycle 1 and must be ignored.
  task automatic run_compare(input logic [W-1:0] xa, input logic [W-1:0] xb, input bit poke);
    int k;
    logic egt, eeq, elt;
    k   = slices_needed(xa, xb);
    egt = (xa > xb);
    eeq = (xa == xb);
    elt = (xa < xb);
    start = 1'b1;
    a = xa;
    b = xb;
    step();
    start = poke;
    a = poke ? ~xa : W'($urandom);
    b = poke ? ~xb : W'($urandom);
    for (int c = 1; c <= k; c++) begin
      check("cmp_busy", busy, 1);
      check("cmp_done", done, 0);
      check("cmp_a_slc", a_slc, slice_of(xa, N - c));
      check("cmp_b_slc", b_slc, slice_of(xb, N - c));
      step();
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
    end
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("done_a_slc", a_slc, slice_of(xa, N - k));
    check("done_b_slc", b_slc, slice_of(xb, N - k));
    check("res_gt", gt, egt);
    check("res_eq", eq, eeq);
    check("res_lt", lt, elt);
    step();
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_a_slc", a_slc, 0);
    check("idle_b_slc", b_slc, 0);
    check("hold_gt", gt, egt);
    check("hold_eq", eq, eeq);
    check("hold_lt", lt, elt);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_flags", {gt, eq, lt}, 3'b000);
    check("rst_a_slc", a_slc, 0);
    check("rst_b_slc", b_slc, 0);
    reset = 1'b0;
    step();
    check("post_rst_idle", busy, 0);

    run_compare(8'hA5, 8'h5A, 1'b0);
    run_compare(8'h3C, 8'h3C, 1'b0);
    run_compare(8'h34, 8'h37, 1'b0);
    run_compare(8'h00, 8'hFF, 1'b1);

    // Reset in the middle of a compare: no done pulse, flags cleared.
    start = 1'b1;
    a = 8'h3C;
    b = 8'h3C;
    step();
    start = 1'b0;
    step();
    check("mid_busy_before_rst", busy, 1);
    reset = 1'b1;
    step();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_flags", {gt, eq, lt}, 3'b000);
    check("mid_rst_a_slc", a_slc, 0);
    reset = 1'b0;
    step();
    check("mid_rst_no_done", done, 0);
    run_compare(8'hC0, 8'hC1, 1'b0);

    for (int n = 0; n < 200; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra ^ W'(1 << $urandom_range(0, W - 1)) : W'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      run_compare(ra, rb, bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
